// File: rtl/instr_encoder_loader_if.sv
// Field-bundle handshake between a boot host (master) and the instruction encoder/loader (slave).
interface instr_encoder_loader_if;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  fmt;
  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [5:0]  funct;
  logic [15:0] imm;
  logic [25:0] target;
  logic        last;

  modport master (
    output in_valid, fmt, opcode, rs, rt, rd, shamt, funct, imm, target, last,
    input  in_ready
  );

  modport slave (
    input  in_valid, fmt, opcode, rs, rt, rd, shamt, funct, imm, target, last,
    output in_ready
  );
endinterface

// File: rtl/instr_encoder_loader.sv
// Packs decoded R/I/J instruction fields into 32-bit words and writes them to
// consecutive instruction-memory addresses from a programmable base.
//
// state  | meaning
// IDLE   | waiting for start
// ACCEPT | in_ready high, waiting for a field bundle
// WRITE  | one-cycle memory write of the captured word (suppressed if illegal/full)
// DONE   | one-cycle done pulse; start here restarts directly
module instr_encoder_loader #(
  parameter int IMEM_DEPTH = 64,
  parameter int ADDR_W     = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [ADDR_W-1:0]        base_addr,
  instr_encoder_loader_if.slave    bus,
  output logic                     imem_we,
  output logic [ADDR_W-1:0]        imem_addr,
  output logic [31:0]              imem_wdata,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [ADDR_W:0]          count
);

  typedef enum logic [1:0] {S_IDLE, S_ACCEPT, S_WRITE, S_DONE} state_t;

  localparam logic [ADDR_W:0] DEPTH_P = (ADDR_W+1)'(IMEM_DEPTH);
  localparam logic [ADDR_W:0] ONE_P   = (ADDR_W+1)'(1);

  state_t          state, state_nxt;
  logic [ADDR_W:0] ptr;
  logic [ADDR_W:0] cnt;
  logic            err_q;
  logic [31:0]     word_q;
  logic            legal_q;
  logic            last_q;

  logic [31:0]     enc_word;
  logic            legal_c;
  logic            hs;
  logic            can_write;
  logic            ready_c;

  always_comb begin
    enc_word = 32'h0;
    legal_c  = 1'b0;
    case (bus.fmt)
      2'b00: begin
        enc_word = {bus.opcode, bus.rs, bus.rt, bus.rd, bus.shamt, bus.funct};
        legal_c  = (bus.opcode == 6'b000000);
      end
      2'b01: begin
        enc_word = {bus.opcode, bus.rs, bus.rt, bus.imm};
        legal_c  = (bus.opcode == 6'b001000) || (bus.opcode == 6'b100111) ||
                   (bus.opcode == 6'b100011) || (bus.opcode == 6'b101011);
      end
      2'b10: begin
        enc_word = {bus.opcode, bus.target};
        legal_c  = (bus.opcode == 6'b000010);
      end
      default: begin
        enc_word = 32'h0;
        legal_c  = 1'b0;
      end
    endcase
  end

  // Pointer is one bit wider than the address so a full memory never wraps.
  assign can_write = legal_q && (ptr < DEPTH_P);
  assign hs        = (state == S_ACCEPT) && bus.in_valid;

  always_comb begin
    state_nxt = state;
    ready_c   = 1'b0;
    imem_we   = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_ACCEPT;
      end
      S_ACCEPT: begin
        ready_c = 1'b1;
        busy    = 1'b1;
        if (bus.in_valid) state_nxt = S_WRITE;
      end
      S_WRITE: begin
        busy      = 1'b1;
        imem_we   = can_write;
        state_nxt = last_q ? S_DONE : S_ACCEPT;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = start ? S_ACCEPT : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr     <= '0;
      cnt     <= '0;
      err_q   <= 1'b0;
      word_q  <= 32'h0;
      legal_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      if (((state == S_IDLE) || (state == S_DONE)) && start) begin
        ptr   <= {1'b0, base_addr};
        cnt   <= '0;
        err_q <= 1'b0;
      end
      if (hs) begin
        word_q  <= enc_word;
        legal_q <= legal_c;
        last_q  <= bus.last;
      end
      if (state == S_WRITE) begin
        if (can_write) begin
          ptr <= ptr + ONE_P;
          cnt <= cnt + ONE_P;
        end else begin
          err_q <= 1'b1;
        end
      end
    end
  end

  assign bus.in_ready = ready_c;
  assign imem_addr    = ptr[ADDR_W-1:0];
  assign imem_wdata   = word_q;
  assign err          = err_q;
  assign count        = cnt;

endmodule
